// File: rtl/video_crop_pkg.sv
// Shared types and defaults for the video crop stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package video_crop_pkg;

   localparam int PX_WIDTH_DEF    = 16;
   localparam int COORD_WIDTH_DEF = 12;

   typedef logic [COORD_WIDTH_DEF-1:0] coord_t;

   // Crop window: first kept column/line and kept width/height.
   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t w;
      coord_t h;
   } crop_win_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   // A runaway line or frame then cannot alias back into the window.
   function automatic coord_t sat_inc(input coord_t v);
      return (v == '1) ? v : v + coord_t'(1);
   endfunction

endpackage

// File: rtl/video_crop_out_reg.sv
// Single-stage valid/ready output register carrying pixel data plus tuser/tlast.
// Latency: 1 cycle from an accepted input beat to the registered output.
// Backpressure: s_rdy = !m_vld | m_rdy; contents held while m_vld & !m_rdy.
module video_crop_out_reg
   import video_crop_pkg::*;
#(
   parameter int PX_WIDTH = PX_WIDTH_DEF
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                s_vld,
   output logic                s_rdy,
   input  logic [PX_WIDTH-1:0] s_dat,
   input  logic                s_user,
   input  logic                s_last,
   output logic                m_vld,
   input  logic                m_rdy,
   output logic [PX_WIDTH-1:0] m_dat,
   output logic                m_user,
   output logic                m_last
);

   // The stage can take a new beat when it is empty or being drained this cycle.
   assign s_rdy = !m_vld | m_rdy;

   // Load on every ready cycle; the payload only moves when a valid beat
   // arrives, so a stalled beat keeps its data and flags untouched.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_vld  <= 1'b0;
         m_dat  <= '0;
         m_user <= 1'b0;
         m_last <= 1'b0;
      end else if (s_rdy) begin
         m_vld <= s_vld;
         if (s_vld) begin
            m_dat  <= s_dat;
            m_user <= s_user;
            m_last <= s_last;
         end
      end
   end

endmodule

// File: rtl/video_crop.sv
// Crops a 16-bit AXI4-Stream video frame to a window latched at frame start (frame counter with VIDEO_CROP_CNT_EN).
// Latency: kept beats appear one cycle after acceptance; dropped beats are consumed at full rate.
// Backpressure: in_tready_o = !out_tvalid_o | out_tready_i through a single output register stage.
module video_crop
   import video_crop_pkg::*;
#(
   parameter int PX_WIDTH    = PX_WIDTH_DEF,
   // Must stay equal to the package width: the window struct is sized by it.
   parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [COORD_WIDTH-1:0] crop_x_i,
   input  logic [COORD_WIDTH-1:0] crop_y_i,
   input  logic [COORD_WIDTH-1:0] crop_w_i,
   input  logic [COORD_WIDTH-1:0] crop_h_i,
   input  logic                   in_tvalid_i,
   output logic                   in_tready_o,
   input  logic [PX_WIDTH-1:0]    in_tdata_i,
   input  logic                   in_tuser_i,
   input  logic                   in_tlast_i,
   output logic                   out_tvalid_o,
   input  logic                   out_tready_i,
   output logic [PX_WIDTH-1:0]    out_tdata_o,
   output logic                   out_tuser_o,
   output logic                   out_tlast_o
`ifdef VIDEO_CROP_CNT_EN
   ,
   output logic [31:0]            frame_cnt_o
`endif
);

   typedef logic [COORD_WIDTH:0] ext_t;

   logic                   synced;
   logic [COORD_WIDTH-1:0] x_cnt;
   logic [COORD_WIDTH-1:0] y_cnt;
   crop_win_t              win_s;
   crop_win_t              win_live;
   crop_win_t              win_cur;
   logic [COORD_WIDTH-1:0] cur_x;
   logic [COORD_WIDTH-1:0] cur_y;
   ext_t                   x_end;
   ext_t                   y_end;
   ext_t                   x_lastcol;
   logic                   frame_active;
   logic                   in_win;
   logic                   keep_vld;
   logic                   kept_user;
   logic                   kept_last;
   logic                   beat_acc;

   // Gather the live CSR window into the shared struct form.
   always_comb begin
      win_live   = '0;
      win_live.x = crop_x_i;
      win_live.y = crop_y_i;
      win_live.w = crop_w_i;
      win_live.h = crop_h_i;
   end

   // Position and window of the beat on the input now. A tuser beat is
   // pixel (0,0) of a new frame and already uses the window it latches.
   always_comb begin
      cur_x   = x_cnt;
      cur_y   = y_cnt;
      win_cur = win_s;
      if (in_tuser_i) begin
         cur_x   = '0;
         cur_y   = '0;
         win_cur = win_live;
      end
   end

   // Window compare, done one bit wider so x+w and y+h never wrap; a zero
   // width or height makes the upper bound equal the lower and keeps nothing.
   always_comb begin
      x_end        = {1'b0, win_cur.x} + {1'b0, win_cur.w};
      y_end        = {1'b0, win_cur.y} + {1'b0, win_cur.h};
      x_lastcol    = x_end - ext_t'(1);
      in_win       = (cur_x >= win_cur.x) && ({1'b0, cur_x} < x_end) &&
                     (cur_y >= win_cur.y) && ({1'b0, cur_y} < y_end);
      frame_active = synced | in_tuser_i;
      keep_vld     = in_tvalid_i & frame_active & in_win;
      kept_user    = (cur_x == win_cur.x) && (cur_y == win_cur.y);
      // A short input line still closes the output line.
      kept_last    = ({1'b0, cur_x} == x_lastcol) | in_tlast_i;
   end

   assign beat_acc = in_tvalid_i & in_tready_o;

   // Track sync, pixel position and the frame's shadow window. Beats seen
   // before the first tuser are swallowed without touching the counters.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         synced <= 1'b0;
         x_cnt  <= '0;
         y_cnt  <= '0;
         win_s  <= '0;
      end else if (beat_acc && frame_active) begin
         if (in_tuser_i) begin
            synced <= 1'b1;
            win_s  <= win_live;
         end
         if (in_tlast_i) begin
            x_cnt <= '0;
            y_cnt <= sat_inc(cur_y);
         end else begin
            x_cnt <= sat_inc(cur_x);
            y_cnt <= cur_y;
         end
      end
   end

   video_crop_out_reg #(
      .PX_WIDTH (PX_WIDTH)
   ) u_out_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .s_vld   (keep_vld),
      .s_rdy   (in_tready_o),
      .s_dat   (in_tdata_i),
      .s_user  (kept_user),
      .s_last  (kept_last),
      .m_vld   (out_tvalid_o),
      .m_rdy   (out_tready_i),
      .m_dat   (out_tdata_o),
      .m_user  (out_tuser_o),
      .m_last  (out_tlast_o)
   );

`ifdef VIDEO_CROP_CNT_EN
   // Count cropped frames as their first pixel is taken downstream.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         frame_cnt_o <= '0;
      end else if (out_tvalid_o && out_tready_i && out_tuser_o) begin
         frame_cnt_o <= frame_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_crop.sv
// Self-checking bench for video_crop: random pixel data, frame-level crop model.
// Latency: checks one-cycle kept-beat latency and stall hold behaviour.
// Backpressure: drives out_tready_i always-on or randomly toggling.
module tb_video_crop;

   localparam int PXW = 16;
   localparam int CW  = 12;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CW-1:0]  crop_x, crop_y, crop_w, crop_h;
   logic           in_tvalid, in_tready, in_tuser, in_tlast;
   logic [PXW-1:0] in_tdata;
   logic           out_tvalid, out_tready, out_tuser, out_tlast;
   logic [PXW-1:0] out_tdata;
`ifdef VIDEO_CROP_CNT_EN
   logic [31:0]    frame_cnt;
`endif

   always #5 clk = ~clk;

   video_crop #(.PX_WIDTH(PXW), .COORD_WIDTH(CW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .crop_x_i     (crop_x),
      .crop_y_i     (crop_y),
      .crop_w_i     (crop_w),
      .crop_h_i     (crop_h),
      .in_tvalid_i  (in_tvalid),
      .in_tready_o  (in_tready),
      .in_tdata_i   (in_tdata),
      .in_tuser_i   (in_tuser),
      .in_tlast_i   (in_tlast),
      .out_tvalid_o (out_tvalid),
      .out_tready_i (out_tready),
      .out_tdata_o  (out_tdata),
      .out_tuser_o  (out_tuser),
      .out_tlast_o  (out_tlast)
`ifdef VIDEO_CROP_CNT_EN
      ,
      .frame_cnt_o  (frame_cnt)
`endif
   );

   typedef struct {
      logic [15:0] d;
      logic        u;
      logic        l;
      logic [11:0] cx, cy, cw, ch;
      bit          kept;
   } ibeat_t;

   ibeat_t      in_q[$];
   logic [17:0] exp_q[$];
   logic [17:0] got_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      assert (act === req) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, act, req);
   endtask

   // Reference: walk a W x H frame and keep pixels inside the window that
   // the tuser pixel carries; crop values on later pixels are cw_after.
   task automatic add_frame(input int W, input int H, input int wx, input int wy,
                            input int ww, input int wh, input int cw_after);
      ibeat_t b;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            b.d    = 16'($urandom);
            b.u    = (r == 0 && c == 0);
            b.l    = (c == W - 1);
            b.cx   = 12'(wx);
            b.cy   = 12'(wy);
            b.ch   = 12'(wh);
            b.cw   = b.u ? 12'(ww) : 12'(cw_after);
            b.kept = (c >= wx) && (c < wx + ww) && (r >= wy) && (r < wy + wh);
            in_q.push_back(b);
            if (b.kept)
               exp_q.push_back({b.d, (c == wx && r == wy), ((c == wx + ww - 1) || (c == W - 1))});
         end
      end
   endtask

   // Beats with no frame start: never produce output while unsynced.
   task automatic add_junk(input int n);
      ibeat_t b;
      for (int i = 0; i < n; i++) begin
         b.d    = 16'($urandom);
         b.u    = 1'b0;
         b.l    = ($urandom_range(0, 4) == 0);
         b.cx   = 12'd0;
         b.cy   = 12'd0;
         b.cw   = 12'd15;
         b.ch   = 12'd15;
         b.kept = 1'b0;
         in_q.push_back(b);
      end
   endtask

   // Drive queued beats until everything is consumed and the output drained.
   task automatic run(input bit rnd_rdy, input bit chk_rdy, input int budget);
      int          cyc;
      bit          done;
      bit          acc_in, stall;
      logic [17:0] held;
      ibeat_t      b;
      cyc  = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         if (in_q.size() > 0) begin
            b         = in_q[0];
            in_tvalid = 1'b1;
            in_tdata  = b.d;
            in_tuser  = b.u;
            in_tlast  = b.l;
            crop_x    = b.cx;
            crop_y    = b.cy;
            crop_w    = b.cw;
            crop_h    = b.ch;
         end else begin
            in_tvalid = 1'b0;
            in_tuser  = 1'b0;
            in_tlast  = 1'b0;
         end
         out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (chk_rdy) check("in_tready_w0", 64'(in_tready), 64'(1));
         acc_in = in_tvalid & in_tready;
         stall  = out_tvalid & !out_tready;
         held   = {out_tdata, out_tuser, out_tlast};
         if (out_tvalid & out_tready) got_q.push_back(held);
         @(posedge clk);
         #1;
         if (stall) check("stall_hold", 64'({out_tvalid, out_tdata, out_tuser, out_tlast}), 64'({1'b1, held}));
         if (acc_in) begin
            b = in_q.pop_front();
            if (b.kept) check("latency", 64'({out_tvalid, out_tdata}), 64'({1'b1, b.d}));
         end
         cyc++;
         if (in_q.size() == 0 && !out_tvalid) done = 1;
         else if (cyc >= budget) begin
            check("drain_timeout", 64'(in_q.size()) + 64'(out_tvalid), 64'(0));
            done = 1;
         end
      end
      in_tvalid = 1'b0;
      in_tuser  = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic compare_out(input string tag);
      int n;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      in_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      ibeat_t b;
      rst_n      = 1'b0;
      crop_x     = '0;
      crop_y     = '0;
      crop_w     = '0;
      crop_h     = '0;
      in_tvalid  = 1'b0;
      in_tdata   = '0;
      in_tuser   = 1'b0;
      in_tlast   = 1'b0;
      out_tready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_out_tvalid", 64'(out_tvalid), 64'(0));
      check("rst_out_tdata", 64'(out_tdata), 64'(0));
      check("rst_out_flags", 64'({out_tuser, out_tlast}), 64'(0));
      check("rst_in_tready", 64'(in_tready), 64'(1));
`ifdef VIDEO_CROP_CNT_EN
      check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
`endif
      rst_n = 1'b1;

      // Mid-frame start: junk is dropped until the first tuser
      add_junk(20);
      add_frame(4, 4, 0, 0, 4, 4, 4);
      run(0, 0, 2000);
      compare_out("unsynced");

      // 8x4 frame, window 2,1,4,2, always ready
      add_frame(8, 4, 2, 1, 4, 2, 4);
      run(0, 0, 2000);
      compare_out("win_ready");

      // Same window under random backpressure, two frames back to back
      add_frame(8, 4, 2, 1, 4, 2, 4);
      add_frame(8, 4, 2, 1, 4, 2, 4);
      run(1, 0, 4000);
      compare_out("win_stall");

      // Width changed mid-frame only takes effect on the next frame
      add_frame(8, 3, 0, 0, 4, 3, 2);
      add_frame(8, 3, 0, 0, 2, 3, 2);
      run(1, 0, 4000);
      compare_out("crop_change");

      // Window past the line end: short lines closed by input tlast
      add_frame(8, 3, 6, 0, 4, 2, 4);
      run(0, 0, 2000);
      compare_out("right_edge");

      // Zero width: nothing out, input never stalled
      add_frame(8, 3, 0, 0, 0, 3, 0);
      run(0, 1, 2000);
      compare_out("zero_w");

      // One-pixel lines: tuser and tlast on the same beat
      add_frame(1, 3, 0, 0, 1, 3, 1);
      run(1, 0, 2000);
      compare_out("one_px");

      // Reset while an output beat is pending
      add_frame(4, 2, 0, 0, 4, 2, 4);
      @(negedge clk);
      b          = in_q[0];
      in_tvalid  = 1'b1;
      in_tdata   = b.d;
      in_tuser   = b.u;
      in_tlast   = b.l;
      crop_x     = b.cx;
      crop_y     = b.cy;
      crop_w     = b.cw;
      crop_h     = b.ch;
      out_tready = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_vld", 64'(out_tvalid), 64'(1));
      @(negedge clk);
      in_tvalid = 1'b0;
      in_tuser  = 1'b0;
      in_tlast  = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_vld", 64'(out_tvalid), 64'(0));
      check("rst_async_rdy", 64'(in_tready), 64'(1));
`ifdef VIDEO_CROP_CNT_EN
      check("rst_async_cnt", 64'(frame_cnt), 64'(0));
`endif
      in_q.delete();
      exp_q.delete();
      got_q.delete();
      @(negedge clk);
      rst_n      = 1'b1;
      out_tready = 1'b1;

      // After reset: wait for tuser again, then three counted frames
      for (int k = 1; k <= 3; k++) begin
         if (k == 1) add_junk(6);
         add_frame(3, 2, 0, 0, 3, 2, 3);
         run(k == 2, 0, 2000);
         compare_out($sformatf("post_rst_f%0d", k));
`ifdef VIDEO_CROP_CNT_EN
         check($sformatf("frame_cnt_f%0d", k), 64'(frame_cnt), 64'(k));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
